// File: rtl/nl_pkg.sv
// Shared types and sizing helpers for the streaming fully-connected layer engine.
package nl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_ARGMAX = 2'd3
    } nl_state_t;

    function automatic int nl_beats(input int n_inputs, input int lanes);
        return (n_inputs + lanes - 1) / lanes;
    endfunction

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int nl_cnt_w(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    // Operands arrive sign-extended to 64 bits; the result is clamped to a w_acc-bit signed range.
    function automatic logic signed [63:0] nl_sat_add(input logic signed [63:0] a,
                                                      input logic signed [63:0] b,
                                                      input int w_acc);
        logic signed [63:0] sum;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sum   = a + b;
        max_v = (64'sd1 <<< (w_acc - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w_acc - 1));
        if (sum > max_v) begin
            return max_v;
        end
        if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/nl_mac_lane_sum.sv
// One neuron's product stage: LANES unsigned-pixel x signed-weight products summed and registered.
module nl_mac_lane_sum
    import nl_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int W_PIXEL  = 8,
    parameter int W_WEIGHT = 8,
    parameter int W_SUM    = 21
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        en,
    input  logic [LANES-1:0]            lane_mask,
    input  logic [LANES*W_PIXEL-1:0]    px_data,
    input  logic [LANES*W_WEIGHT-1:0]   w_data,
    output logic signed [W_SUM-1:0]     lane_sum
);

    localparam int W_PROD = W_PIXEL + W_WEIGHT + 1;

    logic signed [W_PROD-1:0] prod [LANES];
    logic signed [W_SUM-1:0]  sum_next;

    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [W_PROD-1:0] px_ext;
        logic signed [W_PROD-1:0] w_ext;
        // Pixels are unsigned, so a zero MSB keeps them positive in the signed multiply.
        assign px_ext   = W_PROD'(signed'({1'b0, px_data[gi*W_PIXEL +: W_PIXEL]}));
        assign w_ext    = W_PROD'(signed'(w_data[gi*W_WEIGHT +: W_WEIGHT]));
        assign prod[gi] = lane_mask[gi] ? (px_ext * w_ext) : '0;
    end

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_next = sum_next + W_SUM'(prod[i]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_sum <= '0;
        end else if (en) begin
            lane_sum <= sum_next;
        end
    end

endmodule

// File: rtl/neural_layer_engine.sv
// Streaming fully-connected layer: biased dot products over pixel beats, optional ReLU, sequential argmax.
module neural_layer_engine
    import nl_pkg::*;
#(
    parameter int N_NEURONS  = 10,
    parameter int N_INPUTS   = 49,
    parameter int LANES      = 4,
    parameter int W_PIXEL    = 8,
    parameter int W_WEIGHT   = 8,
    parameter int W_BIAS     = 32,
    parameter int W_ACC      = 32,
    localparam int BEATS     = nl_beats(N_INPUTS, LANES),
    localparam int BW        = nl_cnt_w(BEATS),
    localparam int AW        = nl_cnt_w(N_NEURONS)
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic                                abort,
    input  logic                                relu_en,
    input  logic [N_NEURONS*W_BIAS-1:0]         bias_i,
    output logic [BW-1:0]                       w_addr,
    input  logic [N_NEURONS*LANES*W_WEIGHT-1:0] w_data,
    input  logic                                px_valid,
    output logic                                px_ready,
    input  logic [LANES*W_PIXEL-1:0]            px_data,
    output logic [N_NEURONS*W_ACC-1:0]          result_o,
    output logic [AW-1:0]                       argmax_o,
    output logic                                busy,
    output logic                                done
);

    localparam int W_PROD = W_PIXEL + W_WEIGHT + 1;
    localparam int W_SUM  = W_PROD + nl_cnt_w(LANES) + 1;

    nl_state_t               state_reg;
    logic [BW-1:0]           beat_reg;
    logic                    relu_reg;
    logic                    stage_valid_reg;
    logic                    px_ready_reg;
    logic                    done_reg;
    logic [AW-1:0]           scan_reg;
    logic [AW-1:0]           best_idx_reg;
    logic [AW-1:0]           argmax_reg;
    logic signed [W_ACC-1:0] best_val_reg;
    logic signed [W_ACC-1:0] result_vals [N_NEURONS];
    logic signed [W_ACC-1:0] cand;
    logic [LANES-1:0]        lane_mask;
    logic                    accept;
    logic                    start_ok;
    logic                    last_beat;
    logic                    last_scan;
    logic                    cand_wins;

    assign accept    = px_valid & px_ready_reg;
    assign start_ok  = start & ~abort & (state_reg == ST_IDLE);
    assign last_beat = (beat_reg == BW'(BEATS - 1));
    assign last_scan = (scan_reg == AW'(N_NEURONS - 1));
    assign cand      = result_vals[scan_reg];
    assign cand_wins = (scan_reg == '0) || (cand > best_val_reg);

    assign w_addr   = beat_reg;
    assign px_ready = px_ready_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;
    assign argmax_o = argmax_reg;

    genvar gi;
    // Lanes past the end of the pixel vector on the final beat contribute nothing.
    for (gi = 0; gi < LANES; gi++) begin : g_mask
        assign lane_mask[gi] = (int'(beat_reg) * LANES + gi) < N_INPUTS;
    end

    for (gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
        logic signed [W_SUM-1:0] lane_sum;
        logic signed [63:0]      sat_full;
        logic signed [W_ACC-1:0] acc_reg;
        logic signed [W_ACC-1:0] acc_next;
        logic signed [W_ACC-1:0] res_reg;

        nl_mac_lane_sum #(
            .LANES    (LANES),
            .W_PIXEL  (W_PIXEL),
            .W_WEIGHT (W_WEIGHT),
            .W_SUM    (W_SUM)
        ) u_mac (
            .clk       (clk),
            .rstn      (rstn),
            .en        (accept),
            .lane_mask (lane_mask),
            .px_data   (px_data),
            .w_data    (w_data[gi*LANES*W_WEIGHT +: LANES*W_WEIGHT]),
            .lane_sum  (lane_sum)
        );

        assign sat_full = nl_sat_add(64'(acc_reg), 64'(lane_sum), W_ACC);

        always_comb begin
            acc_next = acc_reg;
            if (start_ok) begin
                acc_next = W_ACC'(signed'(bias_i[gi*W_BIAS +: W_BIAS]));
            end else if (stage_valid_reg) begin
                acc_next = sat_full[W_ACC-1:0];
            end
        end

        // The last product retires on the DRAIN edge, so results are taken from acc_next.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                acc_reg <= '0;
                res_reg <= '0;
            end else begin
                acc_reg <= acc_next;
                if (state_reg == ST_DRAIN && !abort) begin
                    res_reg <= (relu_reg && acc_next < 0) ? '0 : acc_next;
                end
            end
        end

        assign result_vals[gi]               = res_reg;
        assign result_o[gi*W_ACC +: W_ACC]   = res_reg;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= ST_IDLE;
            beat_reg        <= '0;
            relu_reg        <= 1'b0;
            stage_valid_reg <= 1'b0;
            px_ready_reg    <= 1'b0;
            done_reg        <= 1'b0;
            scan_reg        <= '0;
            best_idx_reg    <= '0;
            best_val_reg    <= '0;
            argmax_reg      <= '0;
        end else begin
            done_reg        <= 1'b0;
            stage_valid_reg <= accept & ~abort;
            if (abort) begin
                state_reg    <= ST_IDLE;
                px_ready_reg <= 1'b0;
                beat_reg     <= '0;
                scan_reg     <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            beat_reg     <= '0;
                            relu_reg     <= relu_en;
                            px_ready_reg <= 1'b1;
                            state_reg    <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (accept) begin
                            beat_reg <= beat_reg + BW'(1);
                            if (last_beat) begin
                                beat_reg     <= '0;
                                px_ready_reg <= 1'b0;
                                state_reg    <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        scan_reg  <= '0;
                        state_reg <= ST_ARGMAX;
                    end
                    ST_ARGMAX: begin
                        // Strict greater-than keeps the lowest index on ties.
                        if (cand_wins) begin
                            best_val_reg <= cand;
                            best_idx_reg <= scan_reg;
                        end
                        if (last_scan) begin
                            argmax_reg <= cand_wins ? scan_reg : best_idx_reg;
                            done_reg   <= 1'b1;
                            state_reg  <= ST_IDLE;
                        end else begin
                            scan_reg <= scan_reg + AW'(1);
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_neural_layer_engine.sv
// Directed bench for neural_layer_engine: table-driven layers plus abort, busy-start and reset sequences.
module tb_neural_layer_engine;

    localparam int NN    = 10;
    localparam int LANES = 4;
    localparam int BEATS = 13;

    logic               clk = 1'b0;
    logic               rstn;
    logic               start, abort, relu_en, px_valid;
    logic [NN*32-1:0]   bias_v;
    logic [NN*16-1:0]   bias16_v;
    logic [3:0]         w_addr, w_addr16;
    logic [NN*LANES*8-1:0] w_data;
    logic               px_ready, px_ready16;
    logic [LANES*8-1:0] px_data;
    logic [NN*32-1:0]   result_o;
    logic [NN*16-1:0]   result16;
    logic [3:0]         argmax_o, argmax16;
    logic               busy, busy16, done, done16;

    logic [7:0] px_val, wt_val;
    logic       junk;
    int         checks = 0;
    int         failures = 0;

    typedef struct {
        logic [7:0] px;
        logic [7:0] wt;
        int         bias0;
        int         bias_step;
        logic       relu;
        logic       junk;
        logic       gaps;
        int         exp0;
        int         exp_step;
        int         exp_arg;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    neural_layer_engine dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .relu_en(relu_en),
        .bias_i(bias_v), .w_addr(w_addr), .w_data(w_data), .px_valid(px_valid),
        .px_ready(px_ready), .px_data(px_data), .result_o(result_o),
        .argmax_o(argmax_o), .busy(busy), .done(done)
    );

    neural_layer_engine #(.W_ACC(16), .W_BIAS(16)) dut16 (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .relu_en(relu_en),
        .bias_i(bias16_v), .w_addr(w_addr16), .w_data(w_data), .px_valid(px_valid),
        .px_ready(px_ready16), .px_data(px_data), .result_o(result16),
        .argmax_o(argmax16), .busy(busy16), .done(done16)
    );

    // Weight bank: uniform weight, with 0x7F on the padding lanes of the last beat when junk is set.
    always_comb begin
        w_data = '0;
        for (int n = 0; n < NN; n++) begin
            for (int l = 0; l < LANES; l++) begin
                w_data[(n*LANES+l)*8 +: 8] = (junk && w_addr == 4'd12 && l >= 1) ? 8'h7F : wt_val;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic longint expv(input vec_t v, input int n);
        longint e;
        e = longint'(v.exp0) + longint'(n) * longint'(v.exp_step);
        if (v.relu && e < 0) e = 0;
        return e;
    endfunction

    task automatic start_layer(input vec_t v);
        for (int n = 0; n < NN; n++) bias_v[n*32 +: 32] = v.bias0 + n * v.bias_step;
        relu_en = v.relu;
        px_val  = v.px;
        wt_val  = v.wt;
        junk    = v.junk;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic send_beats(input int first, input int last, input bit gaps);
        int b = first;
        int cyc = 0;
        bit gap, rdy;
        while (b < last && cyc < 300) begin
            gap      = gaps && ($urandom_range(0, 2) == 0);
            px_valid = !gap;
            for (int l = 0; l < LANES; l++)
                px_data[l*8 +: 8] = (b == BEATS - 1 && l >= 1) ? (junk ? 8'hFF : 8'h00) : px_val;
            rdy = px_ready;
            @(posedge clk); #1;
            if (!gap && rdy) b++;
            cyc++;
        end
        px_valid = 1'b0;
        chk("beats_accepted", b, last);
    endtask

    task automatic finish_check(input vec_t v, input string tag);
        int k = 0;
        longint early = 0;
        while (done !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) early = $signed(result_o[31:0]);
        end
        chk($sformatf("%s_done_lat", tag), k, 11);
        chk($sformatf("%s_res_early", tag), early, expv(v, 0));
        for (int n = 0; n < NN; n++)
            chk($sformatf("%s_res%0d", tag, n), $signed(result_o[n*32 +: 32]), expv(v, n));
        chk($sformatf("%s_argmax", tag), argmax_o, v.exp_arg);
        $display("layer %s: done_lat=%0d argmax=%0d res0=%0d res9=%0d", tag, k, argmax_o,
                 $signed(result_o[31:0]), $signed(result_o[9*32 +: 32]));
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
    endtask

    initial begin
        vec_t sat_v;
        int seen;
        vecs[0] = '{8'd1,   8'd1,   0,   1,  1'b0, 1'b0, 1'b0, 49,      1,   9};
        vecs[1] = '{8'd1,   8'd1,   0,   1,  1'b0, 1'b1, 1'b1, 49,      1,   9};
        vecs[2] = '{8'd255, 8'hFF,  0,   0,  1'b1, 1'b0, 1'b0, -12495,  0,   0};
        vecs[3] = '{8'd255, 8'hFF,  0,   0,  1'b0, 1'b0, 1'b1, -12495,  0,   0};
        vecs[4] = '{8'd2,   8'd3,   100, -10, 1'b0, 1'b0, 1'b0, 394,    -10, 0};
        vecs[5] = '{8'd0,   8'd5,   -3,  2,  1'b1, 1'b1, 1'b1, -3,      2,   9};
        sat_v   = '{8'd255, 8'h7F,  0,   1,  1'b0, 1'b0, 1'b0, 1586865, 1,   9};

        rstn = 1'b0; start = 1'b0; abort = 1'b0; relu_en = 1'b0; px_valid = 1'b0;
        px_data = '0; bias_v = '0; bias16_v = '0; px_val = '0; wt_val = '0; junk = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        chk("rst_busy", busy, 0);
        chk("rst_px_ready", px_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_result_nz", (result_o != '0), 0);
        chk("rst_argmax", argmax_o, 0);
        chk("rst_w_addr", w_addr, 0);

        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_ready", px_ready, 0);

        for (int i = 0; i < 6; i++) begin
            start_layer(vecs[i]);
            chk($sformatf("v%0d_ready", i), px_ready, 1);
            send_beats(0, BEATS, vecs[i].gaps);
            finish_check(vecs[i], $sformatf("v%0d", i));
        end

        // Saturation on the 16-bit instance; the 32-bit one carries the exact value.
        for (int n = 0; n < NN; n++) bias16_v[n*16 +: 16] = 16'sd32000;
        start_layer(sat_v);
        send_beats(0, BEATS, 1'b0);
        finish_check(sat_v, "sat32");
        chk("sat16_done", done16, 1);
        for (int n = 0; n < NN; n++)
            chk($sformatf("sat16_res%0d", n), $signed(result16[n*16 +: 16]), 32767);
        chk("sat16_argmax", argmax16, 0);
        bias16_v = '0;

        // Abort after five beats: IDLE next cycle, no done, previous results held.
        start_layer(vecs[0]);
        send_beats(0, 5, 1'b1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", px_ready, 0);
        count_done(20, seen);
        chk("abort_no_done", seen, 0);
        for (int n = 0; n < NN; n++)
            chk($sformatf("abort_hold%0d", n), $signed(result_o[n*32 +: 32]), 1586865 + n);
        chk("abort_hold_arg", argmax_o, 9);
        $display("layer abort: busy=%0d done_seen=%0d", busy, seen);
        start_layer(vecs[4]);
        send_beats(0, BEATS, 1'b1);
        finish_check(vecs[4], "post_abort");

        // start during RUN must not reload bias or restart the beat count.
        start_layer(vecs[0]);
        send_beats(0, 3, 1'b0);
        for (int n = 0; n < NN; n++) bias_v[n*32 +: 32] = 1000;
        relu_en = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_start_waddr", w_addr, 3);
        send_beats(3, BEATS, 1'b0);
        finish_check(vecs[0], "busy_start");

        // Asynchronous reset in the middle of ARGMAX.
        start_layer(vecs[4]);
        send_beats(0, BEATS, 1'b0);
        repeat (4) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ready", px_ready, 0);
        chk("mid_rst_result_nz", (result_o != '0), 0);
        chk("mid_rst_argmax", argmax_o, 0);
        chk("mid_rst_w_addr", w_addr, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        count_done(20, seen);
        chk("mid_rst_no_done", seen, 0);
        $display("layer mid_reset: busy=%0d done_seen=%0d", busy, seen);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
